// File: rtl/lift_call_ctrl_if.sv
// Lift-side bundle for the hall-call controller: state code from the lift FSM,
// one-hot call lines back to it, and controller status/debug visibility.
interface lift_call_ctrl_if;
    // Handshake: a call line is the "valid". It stays high until the lift has
    // opened its doors at that floor and reports the floor code again. The
    // one-cycle served pulse is the completion, and no new call is presented
    // in that same cycle.
    logic [2:0] lift_state;
    logic       call_0;
    logic       call_1;
    logic       call_2;
    logic [2:0] pending;
    logic       busy;
    logic       served;
    logic       fault;
    logic [1:0] dbg_state;
    logic [1:0] dbg_cur_floor;

    modport master (
        input  lift_state,
        output call_0, call_1, call_2, pending, busy, served, fault,
        output dbg_state, dbg_cur_floor
    );

    modport slave (
        output lift_state,
        input  call_0, call_1, call_2, pending, busy, served, fault,
        input  dbg_state, dbg_cur_floor
    );
endinterface

// File: rtl/lift_call_ctrl.sv
// Hall-call controller: debounces three floor buttons and latches them as requests.
// It feeds the lift one target call at a time, choosing the nearest floor.
module lift_call_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       btn,
    lift_call_ctrl_if.master lift
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    LS_DOORS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DOORS    = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    sync_1, sync_2, deb, deb_q;
    logic [CW-1:0] db_cnt [3];
    logic [2:0]    pending_r, call_r;
    logic [1:0]    cur_floor, target, sel_floor;
    logic          last_dir, busy_r, served_r, fault_r;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    rise, discard, set_mask, clr_mask;
    logic          lift_at_floor, tmo_hit, done_hit;

    function automatic logic [2:0] floor_bit(input logic [1:0] f);
        return 3'b001 << f;
    endfunction

    // Synchroniser and per-button debounce; a level is accepted only after
    // DEBOUNCE consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            deb_q  <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync_2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise          = deb & ~deb_q;
    assign lift_at_floor = (lift.lift_state <= 3'd2);
    assign tmo_hit       = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
    assign done_hit      = (state == ST_DOORS) && (lift.lift_state == {1'b0, target});
    assign clr_mask      = (done_hit || tmo_hit) ? floor_bit(target) : 3'b000;
    assign set_mask      = rise & ~discard;

    always_comb begin
        discard = 3'b000;
        if (state == ST_IDLE && lift_at_floor && lift.lift_state[1:0] == cur_floor)
            discard = floor_bit(cur_floor);
    end

    // Nearest pending floor; the only equal-distance case is floor 1 with
    // both ends pending, which follows the last travel direction.
    always_comb begin
        sel_floor = cur_floor;
        case (cur_floor)
            2'd0: begin
                if (pending_r[0])      sel_floor = 2'd0;
                else if (pending_r[1]) sel_floor = 2'd1;
                else                   sel_floor = 2'd2;
            end
            2'd1: begin
                if (pending_r[1])                     sel_floor = 2'd1;
                else if (pending_r[0] && pending_r[2]) sel_floor = last_dir ? 2'd2 : 2'd0;
                else if (pending_r[0])                sel_floor = 2'd0;
                else                                  sel_floor = 2'd2;
            end
            default: begin
                if (pending_r[2])      sel_floor = 2'd2;
                else if (pending_r[1]) sel_floor = 2'd1;
                else                   sel_floor = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pending_r <= '0;
            call_r    <= '0;
            cur_floor <= '0;
            target    <= '0;
            last_dir  <= 1'b0;
            busy_r    <= 1'b0;
            served_r  <= 1'b0;
            fault_r   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            served_r  <= 1'b0;
            pending_r <= (pending_r & ~clr_mask) | set_mask;
            if (lift_at_floor) cur_floor <= lift.lift_state[1:0];
            case (state)
                ST_IDLE: begin
                    if (pending_r != 3'b000) begin
                        target  <= sel_floor;
                        call_r  <= floor_bit(sel_floor);
                        busy_r  <= 1'b1;
                        tmo_cnt <= '0;
                        if (sel_floor > cur_floor)      last_dir <= 1'b1;
                        else if (sel_floor < cur_floor) last_dir <= 1'b0;
                        state   <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (tmo_hit) begin
                        call_r  <= '0;
                        busy_r  <= 1'b0;
                        fault_r <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (lift.lift_state == LS_DOORS) state <= ST_DOORS;
                    end
                end
                ST_DOORS: begin
                    if (done_hit) begin
                        call_r   <= '0;
                        busy_r   <= 1'b0;
                        served_r <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (tmo_hit) begin
                        call_r  <= '0;
                        busy_r  <= 1'b0;
                        fault_r <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lift.call_0        = call_r[0];
    assign lift.call_1        = call_r[1];
    assign lift.call_2        = call_r[2];
    assign lift.pending       = pending_r;
    assign lift.busy          = busy_r;
    assign lift.served        = served_r;
    assign lift.fault         = fault_r;
    assign lift.dbg_state     = state;
    assign lift.dbg_cur_floor = cur_floor;
endmodule

// File: tb/tb_lift_call_ctrl.sv
// Directed bench for lift_call_ctrl: a hand-scripted lift model and
// hand-computed expectations for the single-request, bounce, tie-break, discard,
// timeout and reset cases.
module tb_lift_call_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [2:0] calls;
    int         n_checks = 0;
    int         n_fail = 0;
    int         served_count = 0;

    lift_call_ctrl_if lc_if ();

    lift_call_ctrl #(.DEBOUNCE(4), .TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .lift    (lc_if)
    );

    always #5 clk = ~clk;

    assign calls = {lc_if.call_2, lc_if.call_1, lc_if.call_0};

    always @(negedge clk) if (lc_if.served) served_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        btn = 3'b000;
        lc_if.lift_state = 3'b000;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic press(input logic [2:0] b);
        btn = b;
        repeat (10) tick();
        btn = 3'b000;
    endtask

    task automatic wait_call(output logic [2:0] c);
        c = 3'b000;
        for (int n = 0; n < 30; n++) begin
            if (calls != 3'b000) begin
                c = calls;
                return;
            end
            tick();
        end
    endtask

    // Lift model: move (if needed), arrive, doors open 3 cycles, settle at floor.
    task automatic run_lift(input logic [1:0] to, input logic [1:0] from);
        if (to != from) begin
            lc_if.lift_state = (to > from) ? 3'b011 : 3'b100;
            tick();
            lc_if.lift_state = {1'b0, to};
            tick();
        end
        lc_if.lift_state = 3'b101;
        repeat (3) tick();
        lc_if.lift_state = {1'b0, to};
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        int         base;
        int         high;
        logic       bad;

        // Reset values, checked while reset is held.
        reset_n = 1'b0;
        lc_if.lift_state = 3'b000;
        repeat (2) tick();
        check("rst_calls", calls, 3'b000);
        check("rst_pending", lc_if.pending, 3'b000);
        check("rst_busy", lc_if.busy, 1'b0);
        check("rst_served", lc_if.served, 1'b0);
        check("rst_fault", lc_if.fault, 1'b0);
        check("rst_state", lc_if.dbg_state, 2'd0);
        do_reset();

        // Single request to floor 2.
        base = served_count;
        btn = 3'b100;
        repeat (6) tick();
        check("lat6_pending", lc_if.pending, 3'b000);
        tick();
        check("lat7_pending", lc_if.pending, 3'b100);
        check("lat7_call", calls, 3'b000);
        tick();
        check("disp_call", calls, 3'b100);
        check("disp_busy", lc_if.busy, 1'b1);
        lc_if.lift_state = 3'b011;
        tick();
        lc_if.lift_state = 3'b010;
        tick();
        btn = 3'b000;
        lc_if.lift_state = 3'b101;
        tick();
        check("doors_state", lc_if.dbg_state, 2'd2);
        repeat (2) tick();
        check("doors_call_held", calls, 3'b100);
        lc_if.lift_state = 3'b010;
        tick();
        check("done_served", lc_if.served, 1'b1);
        check("done_call", calls, 3'b000);
        check("done_busy", lc_if.busy, 1'b0);
        check("done_pending", lc_if.pending, 3'b000);
        tick();
        check("done_served_low", lc_if.served, 1'b0);
        check("single_served_cnt", served_count - base, 1);
        check("cur_floor_2", lc_if.dbg_cur_floor, 2'd2);

        // Bounce rejection on floor 1.
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn = 3'b010;
            repeat (2) begin tick(); bad = bad | (lc_if.pending != 3'b000) | (calls != 3'b000); end
            btn = 3'b000;
            repeat (2) begin tick(); bad = bad | (lc_if.pending != 3'b000) | (calls != 3'b000); end
        end
        repeat (10) begin tick(); bad = bad | (lc_if.pending != 3'b000) | (calls != 3'b000); end
        check("bounce_quiet", bad, 1'b0);

        // Tie-break with last_dir = up at floor 1.
        do_reset();
        press(3'b010);
        wait_call(c);
        check("tie_up_setup_call", c, 3'b010);
        run_lift(2'd1, 2'd0);
        check("tie_up_setup_served", lc_if.served, 1'b1);
        press(3'b101);
        wait_call(c);
        check("tie_up_first", c, 3'b100);
        run_lift(2'd2, 2'd1);
        check("tie_up_first_served", lc_if.served, 1'b1);
        tick();
        check("tie_up_second", calls, 3'b001);
        check("tie_up_second_served_low", lc_if.served, 1'b0);
        run_lift(2'd0, 2'd2);
        check("tie_up_second_served", lc_if.served, 1'b1);

        // Tie-break with last_dir = down at floor 1 (arrive from floor 2).
        press(3'b100);
        wait_call(c);
        check("tie_dn_setup_up", c, 3'b100);
        run_lift(2'd2, 2'd0);
        press(3'b010);
        wait_call(c);
        check("tie_dn_setup_down", c, 3'b010);
        run_lift(2'd1, 2'd2);
        press(3'b101);
        wait_call(c);
        check("tie_dn_first", c, 3'b001);
        run_lift(2'd0, 2'd1);
        tick();
        check("tie_dn_second", calls, 3'b100);
        run_lift(2'd2, 2'd0);
        check("tie_dn_second_served", lc_if.served, 1'b1);

        // Press at the floor the lift is idle at.
        do_reset();
        base = served_count;
        press(3'b001);
        repeat (10) tick();
        check("here_pending", lc_if.pending, 3'b000);
        check("here_calls", calls, 3'b000);
        check("here_served_cnt", served_count - base, 0);

        // Timeout with the lift parked at floor 0.
        do_reset();
        btn = 3'b010;
        wait_call(c);
        check("tmo_call", c, 3'b010);
        btn = 3'b000;
        high = 1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (lc_if.call_1) high++;
            else break;
        end
        check("tmo_call_cycles", high, 64);
        check("tmo_fault", lc_if.fault, 1'b1);
        check("tmo_pending", lc_if.pending, 3'b000);
        check("tmo_busy", lc_if.busy, 1'b0);
        check("tmo_no_served", lc_if.served, 1'b0);
        repeat (20) tick();
        check("tmo_fault_sticky", lc_if.fault, 1'b1);
        do_reset();
        check("tmo_fault_cleared", lc_if.fault, 1'b0);

        // Asynchronous reset mid-dispatch.
        lc_if.lift_state = 3'b001;
        tick();
        btn = 3'b100;
        wait_call(c);
        check("mid_call", c, 3'b100);
        check("mid_cur_floor", lc_if.dbg_cur_floor, 2'd1);
        btn = 3'b000;
        lc_if.lift_state = 3'b110;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_calls", calls, 3'b000);
        check("async_busy", lc_if.busy, 1'b0);
        check("async_pending", lc_if.pending, 3'b000);
        check("async_cur_floor", lc_if.dbg_cur_floor, 2'd0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("post_rst_state", lc_if.dbg_state, 2'd0);
        check("post_rst_calls", calls, 3'b000);
        check("post_rst_busy", lc_if.busy, 1'b0);
        check("post_rst_cur_floor", lc_if.dbg_cur_floor, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
